moving_average_decimator: RTL



---
 rtl/moving_average_pkg.sv | 32 +++
 rtl/ma_out_fifo.sv | 99 +++++++++
 rtl/moving_average_decimator.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/moving_average_pkg.sv
// -----------------------------------------------------------------------------
// moving_average_pkg
// Shared types and defaults for the moving-average decimator slice.
//   SAMPLE_W       : width of a windowed sum / output sample
//   sample_t       : signed sample type
//   state_t        : decimator control state (WARMUP, RUN)
//   DEF_*          : default WINDOW / DECIM / SHIFT / DEPTH values
//   CNT_W, sat_inc : 8-bit counter width and saturating increment helper
// -----------------------------------------------------------------------------
package moving_average_pkg;

    localparam int SAMPLE_W = 8;
    localparam int CNT_W    = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam int DEF_WINDOW = 16;
    localparam int DEF_DECIM  = 4;
    localparam int DEF_SHIFT  = 4;
    localparam int DEF_DEPTH  = 4;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/ma_out_fifo.sv
// -----------------------------------------------------------------------------
// ma_out_fifo
// Small synchronous FIFO with a registered head-of-queue output.
//   system1000      : clock
//   system1000_rstn : asynchronous reset, active low
//   flush           : synchronous empty; overrides push and pop that cycle
//   push/push_data  : write request; accepted when not full, or when full and
//                     a pop happens in the same cycle
//   pop             : remove head; ignored while empty
//   full/empty      : occupancy flags
//   head_data       : current head word; holds its last value while empty
// -----------------------------------------------------------------------------
module ma_out_fifo
    import moving_average_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = SAMPLE_W
) (
    input  logic             system1000,
    input  logic             system1000_rstn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] occupancy;
    logic [AW-1:0]    rd_next_idx;
    logic [WIDTH-1:0] head_reg;
    logic             pop_eff;
    logic             push_eff;

    // The extra pointer bit tells a full ring from an empty one.
    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign occupancy   = wr_ptr_reg - rd_ptr_reg;
    assign rd_next_idx = rd_ptr_reg[AW-1:0] + AW'(1);

    assign pop_eff  = pop && !empty && !flush;
    // When full, the slot freed by a simultaneous pop is the one being written.
    assign push_eff = push && !flush && (!full || pop_eff);

    // Storage array: no reset so it can map onto RAM.
    always_ff @(posedge system1000) begin
        if (push_eff) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
        end else if (flush) begin
            // head_reg keeps its value so the output holds while empty.
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end

            // Registered head: decide what sits at the head after this edge.
            if (empty) begin
                if (push_eff) begin
                    head_reg <= push_data;
                end
            end else if (pop_eff) begin
                if (occupancy == PTR_W'(1)) begin
                    // Last word leaves; a same-cycle push becomes the new head,
                    // otherwise the old value is held.
                    if (push_eff) begin
                        head_reg <= push_data;
                    end
                end else begin
                    // Second entry is already stored (occupancy >= 2).
                    head_reg <= mem[rd_next_idx];
                end
            end
        end
    end

    assign head_data = head_reg;

endmodule

// File: rtl/moving_average_decimator.sv
// -----------------------------------------------------------------------------
// moving_average_decimator
// Consumes the free-running output of a WINDOW-tap moving-sum stage, skips the
// warm-up sums produced before the window is full, keeps one of every DECIM
// valid sums, scales it by an arithmetic right shift of SHIFT and queues it in
// a DEPTH-entry FIFO. Overflow drops the new sample and is reported.
//   system1000      : clock
//   system1000_rstn : asynchronous reset, active low
//   sum_i           : signed windowed sum, sampled every rising edge
//   clear_i         : synchronous restart (warm-up, flush FIFO, clear flags)
//   out_o           : FIFO head data (holds last value while empty)
//   out_valid_o     : FIFO non-empty
//   out_ready_i     : consumer pops head when out_valid_o && out_ready_i
//   overflow_o      : sticky, a kept sample was dropped on a full FIFO
//   drop_cnt_o      : saturating count of dropped samples
// -----------------------------------------------------------------------------
module moving_average_decimator
    import moving_average_pkg::*;
#(
    parameter int WINDOW = DEF_WINDOW,
    parameter int DECIM  = DEF_DECIM,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       system1000,
    input  logic                       system1000_rstn,
    input  logic signed [SAMPLE_W-1:0] sum_i,
    input  logic                       clear_i,
    output logic signed [SAMPLE_W-1:0] out_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       overflow_o,
    output logic [CNT_W-1:0]           drop_cnt_o
);

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] DEC_LAST  = CNT_W'(DECIM - 1);

    state_t           state_reg,    state_next;
    logic [CNT_W-1:0] warm_cnt_reg, warm_cnt_next;
    logic [CNT_W-1:0] dec_cnt_reg,  dec_cnt_next;
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic             overflow_reg, overflow_next;

    logic             sample_valid;
    logic             keep;
    logic             drop;
    logic             pop_eff;
    logic             fifo_full;
    logic             fifo_empty;
    logic [SAMPLE_W-1:0] fifo_head;
    sample_t          scaled_sum;

    // Arithmetic shift on a signed operand: truncates toward -infinity.
    assign scaled_sum = sum_i >>> SHIFT;

    assign pop_eff = out_ready_i && !fifo_empty;

    // ---------------------------------------------------------------------
    // State and counter registers
    // ---------------------------------------------------------------------
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_reg    <= WARMUP;
            warm_cnt_reg <= '0;
            dec_cnt_reg  <= '0;
            drop_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            warm_cnt_reg <= warm_cnt_next;
            dec_cnt_reg  <= dec_cnt_next;
            drop_cnt_reg <= drop_cnt_next;
            overflow_reg <= overflow_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state: warm-up gating, decimation and drop accounting
    // ---------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        warm_cnt_next = warm_cnt_reg;
        dec_cnt_next  = dec_cnt_reg;
        drop_cnt_next = drop_cnt_reg;
        overflow_next = overflow_reg;
        sample_valid  = 1'b0;
        keep          = 1'b0;
        drop          = 1'b0;

        if (clear_i) begin
            // Restart wins over everything; this edge's sample is discarded.
            state_next    = WARMUP;
            warm_cnt_next = '0;
            dec_cnt_next  = '0;
            drop_cnt_next = '0;
            overflow_next = 1'b0;
        end else begin
            case (state_reg)
                WARMUP: begin
                    warm_cnt_next = warm_cnt_reg + 1'b1;
                    // The sample taken on the last warm-up count is the first
                    // full-window sum and is handled like any RUN sample.
                    if (warm_cnt_reg == WARM_LAST) begin
                        sample_valid = 1'b1;
                        state_next   = RUN;
                    end
                end
                RUN: begin
                    sample_valid = 1'b1;
                end
                default: begin
                    state_next = WARMUP;
                end
            endcase

            if (sample_valid) begin
                keep         = (dec_cnt_reg == '0);
                dec_cnt_next = (dec_cnt_reg == DEC_LAST) ? '0 : dec_cnt_reg + 1'b1;
            end

            // A pop in the same cycle makes room, so only a stalled full
            // FIFO loses the sample.
            drop = keep && fifo_full && !pop_eff;
            if (drop) begin
                overflow_next = 1'b1;
                drop_cnt_next = sat_inc(drop_cnt_reg);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output queue
    // ---------------------------------------------------------------------
    ma_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_out_fifo (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .flush           (clear_i),
        .push            (keep),
        .push_data       (scaled_sum),
        .pop             (out_ready_i),
        .full            (fifo_full),
        .empty           (fifo_empty),
        .head_data       (fifo_head)
    );

    assign out_o       = sample_t'(fifo_head);
    assign out_valid_o = !fifo_empty;
    assign overflow_o  = overflow_reg;
    assign drop_cnt_o  = drop_cnt_reg;

endmodule
